// File: rtl/pc_fetch_sequencer_if.sv
// ----------------------------------------------------------------------------
// pc_fetch_sequencer_if
//   Bundles the two handshakes owned by the fetch sequencer:
//     - instruction-memory fetch (ImemReq/ImemAddr out, ImemAck/ImemData in)
//     - decode hand-off (Instr/InstrPC/InstrValid out, InstrReady in)
//   master : the fetch sequencer side
//   slave  : the memory + decode side (testbench or surrounding datapath)
// Parameters
//   ADDR_W   PC / address width
//   INSTR_W  instruction word width
// ----------------------------------------------------------------------------
interface pc_fetch_sequencer_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    // Instruction-memory fetch channel
    logic               ImemReq;
    logic [ADDR_W-1:0]  ImemAddr;
    logic               ImemAck;
    logic [INSTR_W-1:0] ImemData;

    // Decode hand-off channel
    logic [INSTR_W-1:0] Instr;
    logic [ADDR_W-1:0]  InstrPC;
    logic               InstrValid;
    logic               InstrReady;

    modport master (
        output ImemReq, ImemAddr, Instr, InstrPC, InstrValid,
        input  ImemAck, ImemData, InstrReady
    );

    modport slave (
        input  ImemReq, ImemAddr, Instr, InstrPC, InstrValid,
        output ImemAck, ImemData, InstrReady
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// pc_fetch_sequencer
//   Owns the program counter of the LEGv8 datapath and sequences instruction
//   fetch: one request/ack transaction to instruction memory, then the fetched
//   word is held valid until decode accepts it. Branch redirects resolved
//   downstream replace the sequential PC:
//     target = BrPC + (SignExtImm64 << 2)
//     taken  = Uncondbranch | (Branch & ALUZero)
//   A redirect that arrives while a fetch is outstanding cannot cancel the
//   memory request, so the returning word is discarded (squash) and fetch
//   resumes at the target.
//
// Ports
//   CLK           clock, all state updates on posedge
//   Reset         synchronous, active-high reset
//   fetchBus      master side of pc_fetch_sequencer_if (memory + decode)
//   BrValid       branch resolution valid this cycle
//   BrPC          PC of the resolving branch
//   SignExtImm64  sign-extended word offset
//   Branch        conditional branch
//   ALUZero       condition result
//   Uncondbranch  unconditional branch
//   TakenCnt      taken redirects, saturating      (BRANCH_COUNT_EN only)
//   SquashCnt     discarded fetches, saturating    (BRANCH_COUNT_EN only)
//
// Configuration
//   `define BRANCH_COUNT_EN adds the CNT_W parameter and the TakenCnt /
//   SquashCnt performance counters; without it they do not exist.
// ----------------------------------------------------------------------------
module pc_fetch_sequencer #(
    parameter int                ADDR_W   = 64,
    parameter int                INSTR_W  = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
`ifdef BRANCH_COUNT_EN
    ,parameter int               CNT_W    = 16
`endif
) (
    input  logic                 CLK,
    input  logic                 Reset,
    pc_fetch_sequencer_if.master fetchBus,
    input  logic                 BrValid,
    input  logic [ADDR_W-1:0]    BrPC,
    input  logic [ADDR_W-1:0]    SignExtImm64,
    input  logic                 Branch,
    input  logic                 ALUZero,
    input  logic                 Uncondbranch
`ifdef BRANCH_COUNT_EN
    ,output logic [CNT_W-1:0]    TakenCnt,
    output logic [CNT_W-1:0]     SquashCnt
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] HOLD = 2'd2;

    logic [1:0]         state,      stateNext;
    logic [ADDR_W-1:0]  pc,         pcNext;
    logic [ADDR_W-1:0]  addrReg,    addrNext;
    logic               squash,     squashNext;
    logic               instrValid, validNext;
    logic [INSTR_W-1:0] instrReg,   instrNext;
    logic [ADDR_W-1:0]  instrPcReg, instrPcNext;

    logic               taken;
    logic               redirect;
    logic [ADDR_W-1:0]  target;

    // Branch resolution; the addition wraps modulo 2^ADDR_W by construction.
    assign taken    = Uncondbranch | (Branch & ALUZero);
    assign redirect = BrValid & taken;
    assign target   = BrPC + (SignExtImm64 << 2);

    // ImemAddr has its own register: after a squash the PC already points at
    // the target while the outstanding request must keep the old address.
    assign fetchBus.ImemReq    = (state == REQ);
    assign fetchBus.ImemAddr   = addrReg;
    assign fetchBus.Instr      = instrReg;
    assign fetchBus.InstrPC    = instrPcReg;
    assign fetchBus.InstrValid = instrValid;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        stateNext   = state;
        pcNext      = pc;
        addrNext    = addrReg;
        squashNext  = squash;
        validNext   = instrValid;
        instrNext   = instrReg;
        instrPcNext = instrPcReg;

        case (state)
            IDLE: begin
                stateNext = REQ;
                pcNext    = redirect ? target : pc;
                addrNext  = redirect ? target : pc;
            end

            REQ: begin
                if (fetchBus.ImemAck) begin
                    if (redirect) begin
                        // Data from the old path is dropped; restart at target.
                        pcNext     = target;
                        addrNext   = target;
                        squashNext = 1'b0;
                    end else if (squash) begin
                        // Ack of the abandoned request; PC already holds target.
                        squashNext = 1'b0;
                        addrNext   = pc;
                    end else begin
                        instrNext   = fetchBus.ImemData;
                        instrPcNext = pc;
                        validNext   = 1'b1;
                        pcNext      = pc + ADDR_W'(4);
                        stateNext   = HOLD;
                    end
                end else if (redirect) begin
                    // Request cannot be withdrawn: keep ImemAddr, mark squash.
                    pcNext     = target;
                    squashNext = 1'b1;
                end
            end

            HOLD: begin
                // A handshake in the redirect cycle completes first, so both
                // branches end with the word retired and a fresh request.
                if (redirect) begin
                    validNext = 1'b0;
                    pcNext    = target;
                    addrNext  = target;
                    stateNext = REQ;
                end else if (fetchBus.InstrReady) begin
                    validNext = 1'b0;
                    addrNext  = pc;
                    stateNext = REQ;
                end
            end

            default: stateNext = IDLE;
        endcase
    end

    // NOTE: the reset is synchronous, so only CLK is in the sensitivity list
    // and Reset is tested as the first branch; state uses non-blocking
    // assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            addrReg    <= RESET_PC;
            squash     <= 1'b0;
            instrValid <= 1'b0;
            instrReg   <= '0;
            instrPcReg <= '0;
        end else begin
            state      <= stateNext;
            pc         <= pcNext;
            addrReg    <= addrNext;
            squash     <= squashNext;
            instrValid <= validNext;
            instrReg   <= instrNext;
            instrPcReg <= instrPcNext;
        end
    end

`ifdef BRANCH_COUNT_EN
    logic [CNT_W-1:0] takenCnt;
    logic [CNT_W-1:0] squashCnt;
    logic             squashEvent;

    // A fetch is wasted when an ack is discarded, or when a held word is
    // dropped by a redirect without having been accepted by decode.
    assign squashEvent = ((state == REQ)  && fetchBus.ImemAck && (squash || redirect)) ||
                         ((state == HOLD) && redirect && !fetchBus.InstrReady);

    always_ff @(posedge CLK) begin
        if (Reset) begin
            takenCnt  <= '0;
            squashCnt <= '0;
        end else begin
            if (redirect && (takenCnt != '1)) begin
                takenCnt <= takenCnt + CNT_W'(1);
            end
            if (squashEvent && (squashCnt != '1)) begin
                squashCnt <= squashCnt + CNT_W'(1);
            end
        end
    end

    assign TakenCnt  = takenCnt;
    assign SquashCnt = squashCnt;
`else
    // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// ----------------------------------------------------------------------------
// tb_pc_fetch_sequencer
//   Directed bench for pc_fetch_sequencer. Inputs change and outputs are
//   sampled on the falling edge; the DUT updates on the rising edge.
//   Instruction memory returns 32'hE000_0000 | ImemAddr[31:0] as data.
// ----------------------------------------------------------------------------
module tb_pc_fetch_sequencer;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;

    logic              CLK = 1'b0;
    logic              Reset;
    logic              BrValid;
    logic [ADDR_W-1:0] BrPC;
    logic [ADDR_W-1:0] SignExtImm64;
    logic              Branch;
    logic              ALUZero;
    logic              Uncondbranch;
`ifdef BRANCH_COUNT_EN
    logic [15:0]       TakenCnt;
    logic [15:0]       SquashCnt;
`endif

    int testsRun  = 0;
    int testsFail = 0;

    pc_fetch_sequencer_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) fetchBus ();

    assign fetchBus.ImemData = 32'hE000_0000 | fetchBus.ImemAddr[31:0];

    pc_fetch_sequencer #(
        .ADDR_W   (ADDR_W),
        .INSTR_W  (INSTR_W),
        .RESET_PC ('0)
    ) dut (
        .CLK          (CLK),
        .Reset        (Reset),
        .fetchBus     (fetchBus),
        .BrValid      (BrValid),
        .BrPC         (BrPC),
        .SignExtImm64 (SignExtImm64),
        .Branch       (Branch),
        .ALUZero      (ALUZero),
        .Uncondbranch (Uncondbranch)
`ifdef BRANCH_COUNT_EN
        ,.TakenCnt    (TakenCnt),
        .SquashCnt    (SquashCnt)
`endif
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFail++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
    endtask

    task automatic setBranch(input logic v, input logic [63:0] pcIn, input logic [63:0] imm,
                             input logic br, input logic zero, input logic unc);
        BrValid      = v;
        BrPC         = pcIn;
        SignExtImm64 = imm;
        Branch       = br;
        ALUZero      = zero;
        Uncondbranch = unc;
    endtask

    task automatic doReset();
        Reset = 1'b1;
        cyc();
        cyc();
        Reset = 1'b0;
    endtask

    initial begin
        Reset               = 1'b1;
        fetchBus.ImemAck    = 1'b1;
        fetchBus.InstrReady = 1'b1;
        setBranch(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);

        // ---- Test 1: reset, then back-to-back fetch with ack/ready tied 1
        cyc();
        cyc();
        check("rst_req",    fetchBus.ImemReq,    1'b0);
        check("rst_addr",   fetchBus.ImemAddr,   64'd0);
        check("rst_valid",  fetchBus.InstrValid, 1'b0);
        check("rst_instr",  fetchBus.Instr,      32'd0);
        check("rst_ipc",    fetchBus.InstrPC,    64'd0);
        Reset = 1'b0;
        cyc();
        check("t1_req0",    fetchBus.ImemReq,    1'b1);
        check("t1_addr0",   fetchBus.ImemAddr,   64'd0);
        cyc();
        check("t1_valid0",  fetchBus.InstrValid, 1'b1);
        check("t1_ipc0",    fetchBus.InstrPC,    64'd0);
        check("t1_instr0",  fetchBus.Instr,      32'hE000_0000);
        check("t1_noreq",   fetchBus.ImemReq,    1'b0);
        cyc();
        check("t1_addr4",   fetchBus.ImemAddr,   64'd4);
        check("t1_req4",    fetchBus.ImemReq,    1'b1);
        cyc();
        check("t1_ipc4",    fetchBus.InstrPC,    64'd4);
        cyc();
        check("t1_addr8",   fetchBus.ImemAddr,   64'd8);
        cyc();
        check("t1_ipc8",    fetchBus.InstrPC,    64'd8);

        // ---- Test 2: ack delayed 3 cycles
        fetchBus.ImemAck = 1'b0;
        doReset();
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("t2_req_held",  fetchBus.ImemReq,    1'b1);
            check("t2_addr_held", fetchBus.ImemAddr,   64'd0);
            check("t2_no_valid",  fetchBus.InstrValid, 1'b0);
        end
        fetchBus.ImemAck = 1'b1;
        cyc();
        check("t2_valid",   fetchBus.InstrValid, 1'b1);
        check("t2_ipc",     fetchBus.InstrPC,    64'd0);

        // ---- Test 3: decode stalls 4 cycles in HOLD (ack high is ignored)
        fetchBus.InstrReady = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("t3_valid",   fetchBus.InstrValid, 1'b1);
            check("t3_instr",   fetchBus.Instr,      32'hE000_0000);
            check("t3_ipc",     fetchBus.InstrPC,    64'd0);
            check("t3_noreq",   fetchBus.ImemReq,    1'b0);
        end
        fetchBus.InstrReady = 1'b1;
        cyc();
        check("t3_req",     fetchBus.ImemReq,    1'b1);
        check("t3_addr4",   fetchBus.ImemAddr,   64'd4);
        check("t3_retired", fetchBus.InstrValid, 1'b0);

        // ---- Test 4: redirects (unconditional same cycle as ack, then CBZ-style)
        setBranch(1'b1, 64'd10, 64'd20, 1'b0, 1'b0, 1'b1);
        cyc();
        setBranch(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        check("t4_addr90",  fetchBus.ImemAddr,   64'd90);
        check("t4_req90",   fetchBus.ImemReq,    1'b1);
        check("t4_drop",    fetchBus.InstrValid, 1'b0);
        cyc();
        check("t4_ipc90",   fetchBus.InstrPC,    64'd90);
        check("t4_ins90",   fetchBus.Instr,      32'hE000_005A);
        fetchBus.InstrReady = 1'b0;
        setBranch(1'b1, 64'd16, 64'd2, 1'b1, 1'b1, 1'b0);
        cyc();
        setBranch(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        check("t4_addr24",  fetchBus.ImemAddr,   64'd24);
        check("t4_hold_drop", fetchBus.InstrValid, 1'b0);
        cyc();
        check("t4_ipc24",   fetchBus.InstrPC,    64'd24);
        setBranch(1'b1, 64'd16, 64'd2, 1'b1, 1'b0, 1'b0);
        fetchBus.InstrReady = 1'b1;
        cyc();
        setBranch(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        check("t4_nottaken", fetchBus.ImemAddr,  64'd28);

        // ---- Test 5: redirect while a request is outstanding, then a second one
        fetchBus.ImemAck = 1'b0;
        doReset();
        cyc();
        check("t5_req",     fetchBus.ImemReq,    1'b1);
        setBranch(1'b1, 64'd0, 64'd8, 1'b0, 1'b0, 1'b1);
        cyc();
        check("t5_addr_kept", fetchBus.ImemAddr, 64'd0);
        setBranch(1'b1, 64'd0, 64'd12, 1'b0, 1'b0, 1'b1);
        cyc();
        setBranch(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        check("t5_addr_kept2", fetchBus.ImemAddr, 64'd0);
        check("t5_req_kept",   fetchBus.ImemReq,  1'b1);
        fetchBus.ImemAck = 1'b1;
        cyc();
        check("t5_squashed",   fetchBus.InstrValid, 1'b0);
        check("t5_addr48",     fetchBus.ImemAddr,   64'd48);
        cyc();
        check("t5_valid48",    fetchBus.InstrValid, 1'b1);
        check("t5_ipc48",      fetchBus.InstrPC,    64'd48);
`ifdef BRANCH_COUNT_EN
        check("t5_taken_cnt",  TakenCnt,  16'd2);
        check("t5_squash_cnt", SquashCnt, 16'd1);
`endif

        // ---- Test 6: reset while holding an instruction
        fetchBus.InstrReady = 1'b0;
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        check("t6_valid",   fetchBus.InstrValid, 1'b0);
        check("t6_req",     fetchBus.ImemReq,    1'b0);
        check("t6_addr",    fetchBus.ImemAddr,   64'd0);
`ifdef BRANCH_COUNT_EN
        check("t6_cnt_clr", TakenCnt,  16'd0);
`endif
        cyc();
        check("t6_restart", fetchBus.ImemAddr,   64'd0);
        check("t6_req1",    fetchBus.ImemReq,    1'b1);
        cyc();
        check("t6_ipc0",    fetchBus.InstrPC,    64'd0);

        // ---- Address wrap: PC+4 past the top, negative offset
        setBranch(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 1'b0, 1'b0, 1'b1);
        cyc();
        setBranch(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        check("w_addr_top", fetchBus.ImemAddr,   64'hFFFF_FFFF_FFFF_FFFC);
        cyc();
        check("w_ipc_top",  fetchBus.InstrPC,    64'hFFFF_FFFF_FFFF_FFFC);
        fetchBus.InstrReady = 1'b1;
        cyc();
        check("w_pc_wrap",  fetchBus.ImemAddr,   64'd0);
        setBranch(1'b1, 64'h100, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b1);
        cyc();
        setBranch(1'b0, 64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
        check("w_neg_imm",  fetchBus.ImemAddr,   64'hF8);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFail);
        $finish;
    end

endmodule
